// File: rtl/mem320_pkg.sv
// Shared constants, types and address helper for the 320x240 double-banked
// pixel store scanout path.
package mem320_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int IMG_W     = 320;
    localparam int IMG_H     = 240;
    localparam int BANK_SIZE = IMG_W * IMG_H;

    typedef logic [17:0] addr_t;
    typedef logic [7:0]  pix_t;

    typedef enum logic {
        WAIT_LOAD = 1'b0,
        SCAN      = 1'b1
    } scan_state_t;

    function automatic addr_t bank_base(input logic bank);
        return bank ? addr_t'(BANK_SIZE) : '0;
    endfunction

    // Screen (x,y) to store address with 2x2 pixel doubling; row*320 = row*256 + row*64.
    function automatic addr_t pix_addr(input logic bank, input logic [9:0] x, input logic [9:0] y);
        addr_t row;
        addr_t col;
        row = addr_t'(y >> 1);
        col = addr_t'(x >> 1);
        return bank_base(bank) + (row << 8) + (row << 6) + col;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-enable driven horizontal/vertical counters with sync, active-video
// and frame-boundary decode at the counter stage.
module vga_timing_gen
    import mem320_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_pix_en,
    output logic [9:0] o_hcnt,
    output logic [9:0] o_vcnt,
    output logic       o_active,
    output logic       o_hsync_n,
    output logic       o_vsync_n,
    output logic       o_frame_bnd
);

    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0] r_hcnt;
    logic [9:0] r_vcnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (i_pix_en) begin
            if (r_hcnt == H_LAST) begin
                r_hcnt <= '0;
                r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + 10'd1;
            end else begin
                r_hcnt <= r_hcnt + 10'd1;
            end
        end
    end

    assign o_hcnt      = r_hcnt;
    assign o_vcnt      = r_vcnt;
    assign o_active    = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
    assign o_hsync_n   = !((r_hcnt >= HS_FIRST) && (r_hcnt <= HS_LAST));
    assign o_vsync_n   = !((r_vcnt >= VS_FIRST) && (r_vcnt <= VS_LAST));
    assign o_frame_bnd = (r_hcnt == '0) && (r_vcnt == '0);

endmodule

// File: rtl/mem320_scanout_ctrl.sv
// Scanout controller: VGA timing, pixel-doubled store addressing, bank
// double-buffering on done640 edges, and a two-stage aligned output pipeline.
module mem320_scanout_ctrl
    import mem320_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    input  logic        done640,
    output logic [17:0] mem_addr,
    input  logic [7:0]  mem_data,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [7:0]  pixel,
    output logic        frame_start,
    output logic        bank_active,
    output logic        dbg_state
);

    logic [9:0]  w_hcnt;
    logic [9:0]  w_vcnt;
    logic        w_active;
    logic        w_hsync_n;
    logic        w_vsync_n;
    logic        w_frame_bnd;
    logic        w_edge;
    scan_state_t w_state_nxt;
    logic        w_bank_nxt;
    logic        w_pending_nxt;

    scan_state_t r_state;
    logic        r_bank;
    logic        r_pending;
    logic        r_sync0;
    logic        r_sync1;
    logic        r_sync_prev;
    addr_t       r_mem_addr;
    logic        r_de_d1;
    logic        r_hs_d1;
    logic        r_vs_d1;
    logic        r_fb_d1;
    logic        r_de;
    logic        r_hs;
    logic        r_vs;
    logic        r_fs;
    pix_t        r_pixel;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_pix_en    (pix_en),
        .o_hcnt      (w_hcnt),
        .o_vcnt      (w_vcnt),
        .o_active    (w_active),
        .o_hsync_n   (w_hsync_n),
        .o_vsync_n   (w_vsync_n),
        .o_frame_bnd (w_frame_bnd)
    );

    assign w_edge = r_sync1 && !r_sync_prev;

    // The boundary consumes the old pending; an edge on that same tick re-arms it.
    always_comb begin
        w_state_nxt   = r_state;
        w_bank_nxt    = r_bank;
        w_pending_nxt = r_pending;
        if (w_frame_bnd && r_pending) begin
            w_pending_nxt = 1'b0;
            case (r_state)
                WAIT_LOAD: w_state_nxt = SCAN;
                SCAN:      w_bank_nxt  = !r_bank;
                default:   w_state_nxt = WAIT_LOAD;
            endcase
        end
        if (w_edge) begin
            w_pending_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= WAIT_LOAD;
            r_bank      <= 1'b0;
            r_pending   <= 1'b0;
            r_sync0     <= 1'b0;
            r_sync1     <= 1'b0;
            r_sync_prev <= 1'b0;
            r_mem_addr  <= '0;
            r_de_d1     <= 1'b0;
            r_hs_d1     <= 1'b1;
            r_vs_d1     <= 1'b1;
            r_fb_d1     <= 1'b0;
            r_de        <= 1'b0;
            r_hs        <= 1'b1;
            r_vs        <= 1'b1;
            r_fs        <= 1'b0;
            r_pixel     <= '0;
        end else if (pix_en) begin
            r_state     <= w_state_nxt;
            r_bank      <= w_bank_nxt;
            r_pending   <= w_pending_nxt;
            r_sync0     <= done640;
            r_sync1     <= r_sync0;
            r_sync_prev <= r_sync1;
            // Address uses the post-boundary bank so (0,0) of a new frame reads the new bank.
            r_mem_addr  <= w_active ? pix_addr(w_bank_nxt, w_hcnt, w_vcnt) : bank_base(w_bank_nxt);
            r_de_d1     <= w_active;
            r_hs_d1     <= w_hsync_n;
            r_vs_d1     <= w_vsync_n;
            r_fb_d1     <= w_frame_bnd;
            r_de        <= r_de_d1;
            r_hs        <= r_hs_d1;
            r_vs        <= r_vs_d1;
            r_fs        <= r_fb_d1;
            r_pixel     <= (r_de_d1 && r_state == SCAN) ? mem_data : '0;
        end else begin
            r_fs        <= 1'b0;
        end
    end

    assign mem_addr    = r_mem_addr;
    assign hsync       = r_hs;
    assign vsync       = r_vs;
    assign de          = r_de;
    assign pixel       = r_pixel;
    assign frame_start = r_fs;
    assign bank_active = r_bank;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_mem320_scanout_ctrl.sv
// Bench for mem320_scanout_ctrl using a shrunk timing raster so several
// frames fit in a short run; image mapping and bank layout stay full size.
module tb_mem320_scanout_ctrl;

    localparam int HA = 16, HF = 2, HS = 3, HB = 3, HT = HA + HF + HS + HB;
    localparam int VA = 8,  VF = 2, VS = 2, VB = 2, VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_en;
    logic        done640;
    logic [17:0] mem_addr;
    logic [7:0]  mem_data;
    logic        hsync, vsync, de;
    logic [7:0]  pixel;
    logic        frame_start, bank_active, dbg_state;

    logic [7:0]  mem [0:153599];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;
    assign mem_data = mem[mem_addr];

    mem320_scanout_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_en      (pix_en),
        .done640     (done640),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .pixel       (pixel),
        .frame_start (frame_start),
        .bank_active (bank_active),
        .dbg_state   (dbg_state)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit is_active(input int pos);
        return (pos % HT) < HA && (pos / HT) < VA;
    endfunction

    function automatic bit hs_low(input int pos);
        return (pos % HT) >= HA + HF && (pos % HT) < HA + HF + HS;
    endfunction

    function automatic bit vs_low(input int pos);
        return (pos / HT) >= VA + VF && (pos / HT) < VA + VF + VS;
    endfunction

    function automatic int exp_addr(input int pos, input bit bank);
        int x, y;
        x = pos % HT;
        y = pos / HT;
        if (is_active(pos)) return int'(bank) * 76800 + (y / 2) * 320 + x / 2;
        return int'(bank) * 76800;
    endfunction

    int m_n, pr_pos, e_addr, e_pix;
    bit m_scan, m_bank, m_pend, d_1, d_2, d_3, pr_valid, pr_bank;
    bit e_hs, e_vs, e_de, e_fs;

    always @(posedge clk) begin
        bit edge_seen, scan_old;
        int pos;
        if (!rst_n) begin
            m_n = 0; m_scan = 0; m_bank = 0; m_pend = 0;
            d_1 = 0; d_2 = 0; d_3 = 0; pr_valid = 0; pr_pos = 0; pr_bank = 0;
            e_addr = 0; e_pix = 0; e_hs = 1; e_vs = 1; e_de = 0; e_fs = 0;
        end else if (pix_en) begin
            pos = m_n % FRAME;
            // A done640 rise becomes visible two ticks after it is first sampled.
            edge_seen = d_2 && !d_3;
            d_3 = d_2; d_2 = d_1; d_1 = done640;
            scan_old = m_scan;
            if (pos == 0 && m_pend) begin
                if (m_scan) m_bank = !m_bank;
                else        m_scan = 1;
                m_pend = 0;
            end
            if (edge_seen) m_pend = 1;
            e_addr = exp_addr(pos, m_bank);
            e_de   = pr_valid && is_active(pr_pos);
            e_hs   = !(pr_valid && hs_low(pr_pos));
            e_vs   = !(pr_valid && vs_low(pr_pos));
            e_fs   = pr_valid && pr_pos == 0;
            e_pix  = (e_de && scan_old) ? int'(mem[exp_addr(pr_pos, pr_bank)]) : 0;
            pr_valid = 1; pr_pos = pos; pr_bank = m_bank;
            m_n++;
        end else begin
            e_fs = 0;
        end
        #1;
        chk("model_mem_addr", int'(mem_addr), e_addr);
        chk("model_hsync", int'(hsync), int'(e_hs));
        chk("model_vsync", int'(vsync), int'(e_vs));
        chk("model_de", int'(de), int'(e_de));
        chk("model_pixel", int'(pixel), e_pix);
        chk("model_frame_start", int'(frame_start), int'(e_fs));
        chk("model_bank", int'(bank_active), int'(m_bank));
        chk("model_state", int'(dbg_state), int'(m_scan));
    end

    // ---------------- driver tasks ----------------
    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_fs();
        int k;
        k = 0;
        @(negedge clk);
        while (!frame_start && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("frame_start_seen", int'(frame_start), 1);
    endtask

    task automatic pulse_done(input int hi, input int lo);
        done640 = 1'b1;
        ticks(hi);
        done640 = 1'b0;
        ticks(lo);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_mem_addr"}, int'(mem_addr), 0);
        chk({tag, "_hsync"}, int'(hsync), 1);
        chk({tag, "_vsync"}, int'(vsync), 1);
        chk({tag, "_de"}, int'(de), 0);
        chk({tag, "_pixel"}, int'(pixel), 0);
        chk({tag, "_frame_start"}, int'(frame_start), 0);
        chk({tag, "_bank"}, int'(bank_active), 0);
        chk({tag, "_state"}, int'(dbg_state), 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int hs_cnt, vs_cnt, de_cnt, nz_cnt, max_addr;
        for (int i = 0; i < 76800; i++) begin
            mem[i]         = 8'(i);
            mem[76800 + i] = ~8'(i);
        end
        rst_n = 1'b1; pix_en = 1'b0; done640 = 1'b0;
        #2 rst_n = 1'b0;
        ticks(3);
        chk_reset("por");
        rst_n = 1'b1;

        // Idle frames, including a stretch with pix_en gaps.
        for (int i = 0; i < 60; i++) begin
            pix_en = (i % 4 != 2);
            @(negedge clk);
        end
        pix_en = 1'b1;
        wait_fs();
        hs_cnt = 0; vs_cnt = 0; de_cnt = 0; nz_cnt = 0;
        for (int j = 0; j < FRAME; j++) begin
            hs_cnt += int'(!hsync);
            vs_cnt += int'(!vsync);
            de_cnt += int'(de);
            nz_cnt += int'(pixel != 8'd0);
            @(negedge clk);
        end
        chk("hsync_low_ticks", hs_cnt, 42);
        chk("vsync_low_ticks", vs_cnt, 48);
        chk("de_ticks", de_cnt, 128);
        chk("idle_pixels_nonzero", nz_cnt, 0);

        // First load: WAIT_LOAD -> SCAN showing bank 0.
        ticks(100);
        pulse_done(5, 0);
        wait_fs();
        chk("scan_entered", int'(dbg_state), 1);
        chk("first_bank", int'(bank_active), 0);
        max_addr = 0;
        for (int j = 0; j < FRAME; j++) begin
            if (j == 50) chk("pix_2_2_bank0", int'(pixel), 65);
            if (j == 75) chk("pix_3_3_bank0", int'(pixel), 65);
            if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
            @(negedge clk);
        end
        chk("bank0_max_addr", max_addr, 967);

        // Second load: swap to bank 1 at the next boundary.
        ticks(80);
        pulse_done(5, 0);
        wait_fs();
        chk("bank_after_swap", int'(bank_active), 1);
        chk("addr_origin_bank1", int'(mem_addr), 76800);
        ticks(50);
        chk("pix_2_2_bank1", int'(pixel), 190);
        ticks(132);
        chk("addr_last_bank1", int'(mem_addr), 77767);

        // Three edges in one frame collapse into a single toggle.
        pulse_done(3, 3);
        pulse_done(3, 3);
        pulse_done(3, 3);
        wait_fs();
        chk("triple_edge_one_toggle", int'(bank_active), 0);
        wait_fs();
        chk("no_extra_toggle", int'(bank_active), 0);

        // Edge landing on the frame-boundary tick is serviced one frame later.
        ticks(332);
        done640 = 1'b1;
        wait_fs();
        chk("edge_on_boundary_held", int'(bank_active), 0);
        ticks(10);
        done640 = 1'b0;
        wait_fs();
        chk("edge_on_boundary_late", int'(bank_active), 1);
        chk("addr_origin_late", int'(mem_addr), 76800);

        // Reset mid-frame at output position (10,5).
        ticks(5 * HT + 10);
        rst_n = 1'b0;
        #1;
        chk_reset("mid_rst");
        ticks(3);
        rst_n = 1'b1;
        wait_fs();
        chk("post_rst_bank", int'(bank_active), 0);
        chk("post_rst_state", int'(dbg_state), 0);
        ticks(50);
        chk("post_rst_pixel_blank", int'(pixel), 0);
        ticks(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem320_scanout_ctrl.md
Name: mem320_scanout_ctrl

Overview:
- Scanout controller for the 320x240 8-bit pixel store. The store has two 76800-entry banks: bank 0 at addresses 0..76799, bank 1 at 76800..153599.
- Generates 640x480@60 VGA timing from a pixel-rate enable and pixel-doubles the stored image, so each stored pixel covers a 2x2 block.
- Sequences the store's 18-bit read address and double-buffers between the two banks, swapping on the downscaler's done640 event at frame boundaries.
- Sits between the pixel store (combinational read) and the video DAC/output interface.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- IMG_W, 320, stored image width
- BANK_SIZE, 76800, words per bank

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pix_en  in  1  pixel-rate enable (25 MHz tick); all timing advances only when high
- done640  in  1  level from downscaler; each rising edge means the back bank is freshly written
- mem_addr  out  18  read address to pixel store
- mem_data  in  8  pixel store read data (combinational w.r.t. mem_addr)
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- de  out  1  display enable (active video)
- pixel  out  8  output pixel, 0 when de=0
- frame_start  out  1  one-clk pulse on the pix_en tick where h=0,v=0 reaches the output
- bank_active  out  1  bank currently displayed

Behaviour:
- Reset values (asynchronous assert, synchronous release):
  - hcnt=0, vcnt=0, mem_addr=0, pixel=0, de=0, frame_start=0, bank_active=0, pending=0, state=WAIT_LOAD
  - hsync=1, vsync=1 (both inactive)
- Counters:
  - hcnt wraps at H_TOTAL-1=799 → 0, incrementing vcnt.
  - vcnt wraps at V_TOTAL-1=524 → 0.
  - Both advance only on pix_en.
- Sync decode at counter stage:
  - active = hcnt<640 && vcnt<480
  - hsync_n low for hcnt in [656,751]
  - vsync_n low for vcnt in [490,491]
- Address stage (registered on pix_en):
  - Active: mem_addr = bank_active*76800 + (vcnt>>1)*320 + (hcnt>>1). Multiply by 320 implemented as (y<<8)+(y<<6); result fits 18 bits, max 153599.
  - Blanking: mem_addr = bank_active*76800.
- Output stage (registered on pix_en, one tick after address stage):
  - pixel = mem_data if delayed-active && state==SCAN, else 0.
  - hsync, vsync, de are delayed by the same 2 ticks so all outputs align.
  - Latency from counter position to output: 2 pix_en ticks.
- done640 handling:
  - Synchronised internally with a 2-flop synchroniser, then rising-edge detected.
  - An edge sets pending.
  - Multiple edges before a frame boundary collapse into one swap.
- Frame boundary = counter-stage tick with hcnt=0, vcnt=0.
- State machine:
  - WAIT_LOAD: timing runs, pixel forced 0. At a frame boundary with pending=1 → SCAN; pending cleared; bank_active NOT toggled (first frame shows bank 0).
  - SCAN: at a frame boundary with pending=1, bank_active toggles and pending clears. Otherwise bank_active holds.
- Boundary conditions:
  - Edge detected on the same clk as the frame-boundary tick sets pending and is serviced at the next frame boundary.
  - bank_active never changes mid-frame.
  - pix_en low: every register holds, including the edge detector's pending.
  - Reset mid-frame: immediate return to reset values; scan restarts at (0,0) in WAIT_LOAD.

Decomposition:
- Package mem320_pkg:
  - VGA 640x480 timing constants, IMG_W, IMG_H=240, BANK_SIZE
  - typedef addr_t (logic[17:0]), typedef pix_t (logic[7:0])
  - enum scan_state_t {WAIT_LOAD, SCAN}
- One sub-module, vga_timing_gen: counters plus hsync/vsync/active/frame-boundary decode. The controller adds addressing, banking and the output pipeline.

Test Plan:
- Reset then pix_en every clk, no done640 → hsync low for ticks 656..751 of each 800-tick line; vsync low on lines 490–491; pixel=0 throughout; bank_active=0.
- Store bank0[i]=i[7:0]; pulse done640 mid-frame → first full frame after the boundary: output (h=2,v=2) = bank0[321], (h=3,v=3) = bank0[321]; mem_addr max 76799.
- In SCAN, second done640 pulse → bank_active=1 from the next frame_start; mem_addr at (0,0) = 76800, at (639,479) = 153599.
- Three done640 edges within one frame → exactly one toggle at the next boundary.
- done640 edge on the frame-boundary clk → no toggle that frame; toggle at the following boundary.
- Assert rst_n=0 at (h=300,v=200) for 3 clks → outputs return to reset values immediately; after release state=WAIT_LOAD, bank_active=0, pixel=0.
